// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch state enum, default reset PC and instruction step.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INSTR_STEP   = 32'd4;

endpackage

// File: rtl/if_next_pc.sv
// Combinational next fetch address: reset, boot, redirect, replay, step.
// Ports: reset/state/redirect/handshake in, current if_pc in, pc out.
module if_next_pc
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        reset,
  input  ifu_state_e  state,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        if_valid,
  input  logic        id_ready,
  input  logic [31:0] if_pc,
  output logic [31:0] pc
);

  always_comb begin
    pc = RESET_PC;
    if (!reset) begin
      unique case (state)
        BOOT: pc = redirect_valid ? redirect_pc : RESET_PC;
        RUN: begin
          if (redirect_valid)
            pc = redirect_pc;
          else if (if_valid && !id_ready)
            pc = if_pc;
          else
            pc = if_pc + INSTR_STEP;
        end
        HALT:    pc = if_pc;
        default: pc = RESET_PC;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with stall replay and redirect squash.
// Ports: clk/reset, pc/instruction to imem, id_ready, redirect_*,
// if_valid/if_pc/if_instr to decode, fetch_fault, fetch_count.
// Optional misaligned-redirect halt: define IFU_MISALIGN_CHK_EN.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      pc,
  input  logic [31:0]      instruction,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] fetch_count
);

  ifu_state_e  state;
  logic [31:0] resp_pc;
  logic [31:0] tgt_pc;

`ifdef IFU_MISALIGN_CHK_EN
  logic fault_q;
  logic misalign;
  assign tgt_pc      = redirect_pc;
  assign misalign    = (state == RUN) && redirect_valid &&
                       (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`else
  // Low bits are dropped: the target is forced word aligned.
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign tgt_pc         = {redirect_pc[31:2], 2'b00};
  assign fetch_fault    = 1'b0;
`endif

  // A redirect squashes the word returning this cycle.
  assign if_valid = !reset && (state == RUN) && !redirect_valid;
  assign if_pc    = resp_pc;
  assign if_instr = instruction;

  if_next_pc #(
    .RESET_PC(RESET_PC)
  ) u_next_pc (
    .reset         (reset),
    .state         (state),
    .redirect_valid(redirect_valid),
    .redirect_pc   (tgt_pc),
    .if_valid      (if_valid),
    .id_ready      (id_ready),
    .if_pc         (resp_pc),
    .pc            (pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      resp_pc     <= RESET_PC;
      fetch_count <= '0;
`ifdef IFU_MISALIGN_CHK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      resp_pc <= pc;
      if (if_valid && id_ready)
        fetch_count <= fetch_count + CNT_W'(1);
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
`ifdef IFU_MISALIGN_CHK_EN
          if (misalign) begin
            state   <= HALT;
            fault_q <= 1'b1;
          end
`endif
        end
        HALT:    state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed steps then random.
// Reference is a fetch-stream model; memory is a registered word table.
module tb_if_fetch_unit;

  localparam int CW = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk;
  logic          reset;
  logic [31:0]   pc;
  logic [31:0]   instruction;
  logic          id_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic          fetch_fault;
  logic [CW-1:0] fetch_count;

  if_fetch_unit #(
    .RESET_PC(RPC),
    .CNT_W   (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .instruction   (instruction),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) instruction <= word(pc);

  int n_cmp = 0;
  int n_err = 0;

  // Model of the fetch stream
  bit          m_live = 0;
  bit          m_boot = 1;
  bit          m_halt = 0;
  bit          m_fault = 0;
  logic [31:0] m_cur = RPC;
  int          m_cnt = 0;

  // Observations from the most recent step
  logic [31:0] o_ifpc, o_instr;
  logic        o_valid;
  logic [CW-1:0] o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc,
                      input bit rdy);
    logic [31:0] tgt, e_pc;
    bit e_valid;
    reset = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    id_ready = rdy;
`ifdef IFU_MISALIGN_CHK_EN
    tgt = rpc;
`else
    tgt = rpc & ~32'h3;
`endif
    e_valid = !r && !m_boot && !m_halt && !rv;
    if (r) e_pc = RPC;
    else if (m_boot) e_pc = rv ? tgt : RPC;
    else if (m_halt) e_pc = m_cur;
    else if (rv) e_pc = tgt;
    else if (!rdy) e_pc = m_cur;
    else e_pc = m_cur + 32'd4;
    @(negedge clk);
    o_ifpc = if_pc;
    o_instr = if_instr;
    o_valid = if_valid;
    o_cnt = fetch_count;
    chk("pc", pc, e_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, e_valid});
    if (m_live) begin
      chk("if_pc", if_pc, m_cur);
      chk("fetch_count", {28'b0, fetch_count}, 32'(m_cnt));
      chk("fetch_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
      if (e_valid) chk("if_instr", if_instr, word(m_cur));
    end
    @(posedge clk);
    if (r) begin
      m_boot = 1; m_halt = 0; m_fault = 0; m_cur = RPC; m_cnt = 0;
    end else begin
      if (e_valid && rdy) m_cnt = (m_cnt + 1) % (1 << CW);
      if (!m_boot && !m_halt && rv && tgt[1:0] != 2'b00) begin
        m_halt = 1; m_fault = 1;
      end
      m_cur = e_pc;
      m_boot = 0;
    end
    m_live = 1;
    #1;
  endtask

  int c0;

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    repeat (3) step(1, 0, 0, 1);

    // boot and first two words
    step(0, 0, 0, 1);
    chk("boot_valid", {31'b0, o_valid}, 32'd0);
    step(0, 0, 0, 1);
    chk("w0_valid", {31'b0, o_valid}, 32'd1);
    chk("w0_pc", o_ifpc, 32'h0);
    chk("w0_instr", o_instr, 32'h0000_0013);
    step(0, 0, 0, 1);
    chk("w1_pc", o_ifpc, 32'h4);
    chk("w1_instr", o_instr, 32'h0050_0093);

    // three-cycle stall at 0x8
    c0 = m_cnt;
    repeat (3) begin
      step(0, 0, 0, 0);
      chk("stall_pc", o_ifpc, 32'h8);
      chk("stall_instr", o_instr, word(32'h8));
    end
    step(0, 0, 0, 1);
    chk("stall_acc", o_ifpc, 32'h8);
    step(0, 0, 0, 1);
    chk("after_stall", o_ifpc, 32'hC);
    chk("stall_cnt", {28'b0, o_cnt}, 32'((c0 + 1) % (1 << CW)));

    // redirect at 0x10 to 0x40
    step(0, 1, 32'h40, 1);
    chk("redir_squash", {31'b0, o_valid}, 32'd0);
    chk("redir_from", o_ifpc, 32'h10);
    step(0, 0, 0, 1);
    chk("redir_pc", o_ifpc, 32'h40);
    chk("redir_instr", o_instr, word(32'h40));

    // redirect beats stall
    step(0, 1, 32'h80, 0);
    step(0, 0, 0, 1);
    chk("redir_stall", o_ifpc, 32'h80);

    // misaligned redirect
    step(0, 1, 32'h42, 1);
    step(0, 0, 0, 1);
`ifdef IFU_MISALIGN_CHK_EN
    chk("mis_valid", {31'b0, o_valid}, 32'd0);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    step(0, 1, 32'h100, 1);
    chk("halt_valid", {31'b0, o_valid}, 32'd0);
`else
    chk("mis_pc", o_ifpc, 32'h40);
    chk("mis_valid", {31'b0, o_valid}, 32'd1);
`endif

    // reset during a stall at 0x20
    repeat (2) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 1, 32'h20, 1);
    step(0, 0, 0, 0);
    chk("stall20", o_ifpc, 32'h20);
    step(0, 0, 0, 0);
    step(1, 1, 32'h60, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_pc", o_ifpc, RPC);
    chk("rst_valid", {31'b0, o_valid}, 32'd1);
    chk("rst_cnt", {28'b0, o_cnt}, 32'd0);

    // address wrap
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    chk("wrap_hi", o_ifpc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    chk("wrap_lo", o_ifpc, 32'h0);
    chk("wrap_instr", o_instr, 32'h0000_0013);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 63) == 0,
           $urandom_range(0, 7) == 0,
           $urandom,
           $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter CNT_W, default 32, SHALL be the width of fetch_count.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 pc  output  32  fetch address to the instruction memory, which registers it and returns data next cycle.
REQ-006 instruction  input  32  instruction memory data for the address driven on pc the previous cycle.
REQ-007 id_ready  input  1  decode accepts if_instr this cycle.
REQ-008 redirect_valid  input  1  branch/jump/flush redirect request.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 if_valid  output  1  if_pc/if_instr hold a valid fetched instruction.
REQ-011 if_pc  output  32  address of if_instr.
REQ-012 if_instr  output  32  fetched instruction, equal to the instruction input.
REQ-013 fetch_fault  output  1  misaligned redirect fault, sticky; tied 0 when the feature is compiled out.
REQ-014 fetch_count  output  CNT_W  count of instructions accepted by decode.

Function
REQ-015 States SHALL be BOOT, RUN and HALT; HALT exists only with IFU_MISALIGN_CHK_EN.
REQ-016 BOOT: pc = redirect_valid ? redirect_pc : RESET_PC; if_valid = 0; next state RUN.
REQ-017 A register resp_pc SHALL capture pc every cycle; if_pc SHALL equal resp_pc.
REQ-018 RUN, priority high to low: redirect_valid -> pc = redirect_pc; if_valid && !id_ready -> pc = if_pc (replay); otherwise pc = if_pc + 4.
REQ-019 Replay on stall SHALL keep if_pc/if_instr stable for the whole stall, with no instruction lost or duplicated.
REQ-020 if_valid SHALL be 1 in RUN except in a cycle with redirect_valid = 1, when it SHALL be 0 (wrong-path squash).
REQ-021 The instruction at redirect_pc SHALL appear with if_valid = 1 in the cycle after the redirect (one-cycle bubble).
REQ-022 pc + 4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 fetch_count SHALL increment by 1 on each cycle with if_valid && id_ready, and SHALL wrap at 2^CNT_W.
REQ-024 redirect_valid with id_ready = 0 SHALL still redirect; the redirect has priority over the stall.

Reset
REQ-025 While reset = 1: state = BOOT, resp_pc = RESET_PC, fetch_count = 0, fetch_fault = 0, if_valid = 0, pc = RESET_PC.
REQ-026 Reset asserted mid-stall or mid-redirect SHALL abandon all in-flight fetches; the first valid instruction after reset SHALL be at RESET_PC.

Configuration
REQ-027 Macro IFU_MISALIGN_CHK_EN, when defined: a RUN-state redirect with redirect_pc[1:0] != 0 SHALL set fetch_fault, enter HALT and drive if_valid = 0.
REQ-028 In HALT, pc SHALL hold the faulting redirect_pc; HALT SHALL be left only by reset.
REQ-029 When the macro is undefined, no HALT state exists, fetch_fault = 0, and redirect_pc[1:0] SHALL be ignored (treated as 2'b00).

Structure
REQ-030 A shared package SHALL hold the state enum (BOOT/RUN/HALT), the default RESET_PC and the instruction-step constant 4.
REQ-031 One sub-module, if_next_pc, SHALL implement the combinational next-pc priority mux; the registers and state machine stay in if_fetch_unit.

Verification
REQ-032 Reset release, id_ready = 1, memory 0x0 = 0x00000013 and 0x4 = 0x00500093 -> pc is 0x0 then 0x4; if_valid rises one cycle after BOOT with if_pc 0x0, if_instr 0x00000013.
REQ-033 id_ready = 0 for 3 cycles while if_pc = 0x8 -> if_pc/if_instr stable for 3 cycles; then 0xC follows; fetch_count increments once for 0x8.
REQ-034 redirect_valid with redirect_pc = 0x40 while if_pc = 0x10 -> if_valid = 0 that cycle; next cycle if_pc = 0x40 with the word at 0x40.
REQ-035 Simultaneous redirect 0x80 and id_ready = 0 -> redirect taken; if_pc = 0x80 next cycle.
REQ-036 With IFU_MISALIGN_CHK_EN, redirect_pc = 0x42 -> fetch_fault = 1 and if_valid = 0 until reset; without the macro, fetch resumes at 0x40.
REQ-037 Reset asserted during a stall at 0x20 -> after release, first valid if_pc = RESET_PC and fetch_count = 0.
